// File: rtl/alarm_ring_if.sv
// Signal bundle between the alarm ring sequencer and its neighbours:
// time/alarm compare inputs, debounced buttons, ring status and forwarded buttons.
interface alarm_ring_if;
  logic       alarm_en;
  logic [7:0] cur_hour;
  logic [7:0] cur_min;
  logic [7:0] alm_hour;
  logic [7:0] alm_min;
  logic       btn_stop;
  logic       btn_snooze;
  logic       btn_switch;
  logic       ringing;
  logic       buzzer_en;
  logic [1:0] state;
  logic [1:0] snooze_cnt;
  logic       stop_out;
  logic       snooze_out;
  logic       switch_out;

  modport master (
    output alarm_en, cur_hour, cur_min, alm_hour, alm_min,
    output btn_stop, btn_snooze, btn_switch,
    input  ringing, buzzer_en, state, snooze_cnt,
    input  stop_out, snooze_out, switch_out
  );

  modport slave (
    input  alarm_en, cur_hour, cur_min, alm_hour, alm_min,
    input  btn_stop, btn_snooze, btn_switch,
    output ringing, buzzer_en, state, snooze_cnt,
    output stop_out, snooze_out, switch_out
  );
endinterface

// File: rtl/alarm_ring_ctl.sv
// Alarm ring sequencer: time match, ring/snooze/done FSM, beep gating and
// button arbitration between the alarm and the rest of the clock.
module alarm_ring_ctl #(
  parameter int unsigned TICK_MS    = 1000,
  parameter int unsigned BEEP_MS    = 500,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input logic         clk_1khz,
  input logic         rst,
  alarm_ring_if.slave bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRing   = 2'd1;
  localparam logic [1:0] StSnooze = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam int unsigned SecMax = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int unsigned MsW    = (TICK_MS > 1) ? $clog2(TICK_MS) : 1;
  localparam int unsigned SecW   = $clog2(SecMax + 1);

  localparam logic [MsW-1:0]  MsLast     = MsW'(TICK_MS - 1);
  localparam logic [SecW-1:0] RingLast   = SecW'(RING_SEC - 1);
  localparam logic [SecW-1:0] SnoozeLast = SecW'(SNOOZE_SEC - 1);

  logic [1:0]      state_q, state_d;
  logic [MsW-1:0]  ms_q, ms_d;
  logic [SecW-1:0] sec_q, sec_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [2:0]      btn_prev_q;
  logic [2:0]      mask_q, mask_d;
  logic [2:0]      fwd_q, fwd_d;
  logic            ringing_q, ringing_d;
  logic            buzzer_q, buzzer_d;

  // Button vectors are ordered {switch, snooze, stop}.
  logic [2:0] btn;
  logic [2:0] btn_edge;
  logic [2:0] mask_set;
  logic       match;
  logic       period_done;
  logic       snooze_req;

  always_comb begin
    btn      = {bus.btn_switch, bus.btn_snooze, bus.btn_stop};
    btn_edge = btn & ~btn_prev_q;
    match    = bus.alarm_en && (bus.cur_hour == bus.alm_hour) && (bus.cur_min == bus.alm_min);
    // Last cycle of the ring or snooze period; the transition lands on the next edge.
    period_done = (ms_q == MsLast) &&
                  (sec_q == ((state_q == StRing) ? RingLast : SnoozeLast));
  end

  always_comb begin
    state_d    = state_q;
    ms_d       = ms_q;
    sec_d      = sec_q;
    cnt_d      = cnt_q;
    mask_set   = 3'b000;
    snooze_req = 1'b0;

    case (state_q)
      StIdle: begin
        if (match) begin
          state_d = StRing;
          ms_d    = '0;
          sec_d   = '0;
        end
      end

      StRing: begin
        snooze_req = btn_edge[1] || period_done;
        if (!bus.alarm_en || btn_edge[0]) begin
          state_d = StDone;
        end else if (snooze_req) begin
          if (32'(cnt_q) < MAX_SNOOZE) begin
            state_d = StSnooze;
            cnt_d   = cnt_q + 2'd1;
          end else begin
            state_d = StDone;
          end
        end

        if (state_d != StRing) begin
          // Whatever is held when ringing stops must not leak to the rest of the clock.
          mask_set = 3'b111;
          ms_d     = '0;
          sec_d    = '0;
        end else if (ms_q == MsLast) begin
          ms_d  = '0;
          sec_d = sec_q + 1'b1;
        end else begin
          ms_d = ms_q + 1'b1;
        end
      end

      StSnooze: begin
        if (!bus.alarm_en || btn_edge[0]) begin
          state_d     = StDone;
          mask_set[0] = btn_edge[0];
        end else if (period_done) begin
          state_d = StRing;
          ms_d    = '0;
          sec_d   = '0;
        end else if (ms_q == MsLast) begin
          ms_d  = '0;
          sec_d = sec_q + 1'b1;
        end else begin
          ms_d = ms_q + 1'b1;
        end
      end

      StDone: begin
        if (!match) begin
          state_d = StIdle;
          cnt_d   = 2'd0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    mask_d    = (mask_q | mask_set) & btn;
    fwd_d     = (state_d == StRing) ? 3'b000 : (btn & ~mask_d);
    ringing_d = (state_d == StRing);
    buzzer_d  = ringing_d && (32'(ms_d) < BEEP_MS);
  end

  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      state_q    <= StIdle;
      ms_q       <= '0;
      sec_q      <= '0;
      cnt_q      <= 2'd0;
      btn_prev_q <= 3'b000;
      mask_q     <= 3'b000;
      fwd_q      <= 3'b000;
      ringing_q  <= 1'b0;
      buzzer_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ms_q       <= ms_d;
      sec_q      <= sec_d;
      cnt_q      <= cnt_d;
      btn_prev_q <= btn;
      mask_q     <= mask_d;
      fwd_q      <= fwd_d;
      ringing_q  <= ringing_d;
      buzzer_q   <= buzzer_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.snooze_cnt = cnt_q;
  assign bus.ringing    = ringing_q;
  assign bus.buzzer_en  = buzzer_q;
  assign bus.stop_out   = fwd_q[0];
  assign bus.snooze_out = fwd_q[1];
  assign bus.switch_out = fwd_q[2];

endmodule

// File: doc/alarm_ring_ctl.md
Name: alarm_ring_ctl

Overview:
Sequences alarm ringing for the digital clock. It compares current time against the stored alarm time, runs the ring/snooze/dismiss state machine, and produces the buzzer enable and the alarm_ringing flag. It also owns the three debounced buttons: while ringing it consumes them, and at all other times it forwards them to the mode, clock, timer and alarm-set logic. It sits between the debouncers, the clock and alarm_set blocks, and the buzzer and mode control.

Parameters:
TICK_MS, 1000, clk_1khz cycles per second tick.
BEEP_MS, 500, on-time of each beep within a second (off for the remainder).
RING_SEC, 60, seconds of continuous ringing before auto-snooze.
SNOOZE_SEC, 300, snooze duration in seconds.
MAX_SNOOZE, 3, snoozes allowed before a snooze request acts as stop.

Ports:
clk_1khz  in  1  system tick clock, 1 kHz
rst  in  1  synchronous reset, active-high
alarm_en  in  1  alarm armed
cur_hour  in  8  current hour, BCD 00-23
cur_min  in  8  current minute, BCD 00-59
alm_hour  in  8  alarm hour, BCD
alm_min  in  8  alarm minute, BCD
btn_stop  in  1  debounced level (all_switch button)
btn_snooze  in  1  debounced level (add button)
btn_switch  in  1  debounced level (switch button)
ringing  out  1  alarm_ringing flag to mode control
buzzer_en  out  1  gated beep enable to buzzer
state  out  2  0=IDLE 1=RING 2=SNOOZE 3=DONE
snooze_cnt  out  2  snoozes used this alarm
stop_out, snooze_out, switch_out  out  1 each  buttons forwarded to the rest of the design

Behaviour:
- Reset (synchronous): state=IDLE; snooze_cnt=0; ms/sec counters=0; ringing=0; buzzer_en=0; all forwarded buttons=0; button masks cleared. A reset mid-ring or mid-snooze aborts immediately.
- match = alarm_en and (cur_hour==alm_hour) and (cur_min==alm_min).
- Rising edges are detected internally with one registered previous-value per button. Edge is valid the cycle the input is 1 and the previous value was 0.
- IDLE -> RING on match. On entry: ms_cnt=0, sec_cnt=0.
- RING:
  - ringing=1.
  - buzzer_en=1 while ms_cnt<BEEP_MS, otherwise 0. ms_cnt wraps at TICK_MS-1 and increments sec_cnt.
  - Stop edge -> DONE.
  - Snooze edge with snooze_cnt<MAX_SNOOZE -> SNOOZE and snooze_cnt+1.
  - Snooze edge with snooze_cnt==MAX_SNOOZE -> DONE.
  - Stop and snooze edges in the same cycle: stop wins.
  - sec_cnt reaches RING_SEC with no edge: treated as a snooze request (same rules as above).
  - btn_switch edges are ignored.
- SNOOZE:
  - ringing=0, buzzer_en=0.
  - Counts SNOOZE_SEC seconds, then -> RING with counters cleared.
  - Stop edge -> DONE.
  - Match is not re-evaluated during SNOOZE.
- DONE:
  - ringing=0.
  - Waits until match=0 (minute changed or alarm disarmed), then -> IDLE with snooze_cnt=0.
  - This prevents retrigger within the same minute.
- alarm_en=0 in RING or SNOOZE -> DONE on the next edge.
- Button arbitration:
  - In RING, all forwarded outputs are 0.
  - In SNOOZE, DONE and IDLE, forwarded outputs equal the input levels. Exception: stop_out and snooze_out also pass in SNOOZE, but the edge used for the SNOOZE->DONE transition is still consumed.
  - Any button held at the moment RING is exited stays masked (forwarded 0) until it is released. The press that silences the alarm never reaches mode or set logic.
- Latency: all outputs are registered. A transition is taken one cycle after its cause, and buzzer_en changes in the same cycle as the state change.
- Counter widths: ms_cnt holds TICK_MS-1; sec_cnt holds max(RING_SEC, SNOOZE_SEC); snooze_cnt saturates at MAX_SNOOZE.

Test Plan:
- Trigger/beep (TICK_MS=10, BEEP_MS=5): alarm 07:30, time steps 07:29 -> 07:30 -> state=RING, ringing=1. buzzer_en runs a 5-high/5-low pattern starting on the first RING cycle.
- Stop plus mask: press btn_stop during RING -> DONE next cycle, stop_out stays 0 until release. Time stays 07:30 -> state remains DONE. Time 07:31 -> IDLE, snooze_cnt=0.
- Snooze limit (RING_SEC=2, SNOOZE_SEC=3, MAX_SNOOZE=3): three snooze presses -> SNOOZE each time, snooze_cnt 1, 2, 3, RING returns after 30 cycles. Fourth press -> DONE.
- Auto-snooze: no button for RING_SEC seconds -> SNOOZE, snooze_cnt+1. On the fourth timeout -> DONE.
- Simultaneous edges: btn_stop and btn_snooze rise in the same cycle in RING -> DONE, snooze_cnt unchanged.
- Pass-through and reset: IDLE, toggle btn_switch -> switch_out follows with 1-cycle latency. Assert rst during SNOOZE -> next cycle state=IDLE and all outputs 0.
